// File: rtl/sym_delay_search_if.sv
// Bundles the sweep handshake and the alignment bus between the controller
// and its neighbours (err_sq_gen upstream, the config_*_delay blocks downstream).
interface sym_delay_search_if;
  logic        start;
  logic        hold;
  logic [17:0] acc_sq_err;
  logic [7:0]  sym_delay_out;
  logic [1:0]  sam_phase_out;
  logic [17:0] best_err;
  logic        busy;
  logic        done;
  logic        locked;

  // Whoever requests sweeps and supplies the error measurement
  modport master (
    output start, hold, acc_sq_err,
    input  sym_delay_out, sam_phase_out, best_err, busy, done, locked
  );

  // The alignment search controller itself
  modport slave (
    input  start, hold, acc_sq_err,
    output sym_delay_out, sam_phase_out, best_err, busy, done, locked
  );
endinterface

// File: rtl/sym_delay_search.sv
// Receiver alignment search. Walks every {symbol delay, sample phase} candidate
// in the configured window, lets the error accumulator settle, reads the squared
// slicer error for each candidate and finally applies the lowest-error alignment.
module sym_delay_search #(
  parameter logic [7:0]  DELAY_MIN      = 8'd48,
  parameter logic [7:0]  DELAY_MAX      = 8'd56,
  parameter logic [7:0]  DEFAULT_DELAY  = 8'd52,
  parameter logic [1:0]  SETTLE_PERIODS = 2'd1,
  parameter logic [17:0] LOCK_THRESH    = 18'd4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  sym_delay_search_if.slave  bus
);

  localparam logic [17:0] ERR_MAX = 18'h3FFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    CAPTURE,
    APPLY
  } state_t;

  state_t      state, state_next;

  logic [7:0]  sym_delay, sym_delay_next;
  logic [1:0]  sam_phase, sam_phase_next;
  logic [7:0]  best_delay, best_delay_next;
  logic [1:0]  best_phase, best_phase_next;
  logic [17:0] best_err_r, best_err_next;
  logic [1:0]  settle_cnt, settle_cnt_next;
  logic        busy_r, busy_next;
  logic        done_r, done_next;
  logic        locked_r, locked_next;

  logic        last_cand;
  logic        better;

  // The final candidate is phase 3 at the top of the delay window
  assign last_cand = (sym_delay == DELAY_MAX) && (sam_phase == 2'd3);

  // Strict compare so that equal errors keep the earliest candidate
  assign better = (bus.acc_sq_err < best_err_r);

  // Next-state and datapath decisions; everything holds unless a state acts on it
  always_comb begin
    state_next      = state;
    sym_delay_next  = sym_delay;
    sam_phase_next  = sam_phase;
    best_delay_next = best_delay;
    best_phase_next = best_phase;
    best_err_next   = best_err_r;
    settle_cnt_next = settle_cnt;
    busy_next       = busy_r;
    done_next       = 1'b0;
    locked_next     = locked_r;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sym_delay_next  = DELAY_MIN;
          sam_phase_next  = 2'd0;
          best_delay_next = DELAY_MIN;
          best_phase_next = 2'd0;
          best_err_next   = ERR_MAX;
          locked_next     = 1'b0;
          busy_next       = 1'b1;
          settle_cnt_next = SETTLE_PERIODS;
          state_next      = SETTLE;
        end
      end

      SETTLE: begin
        if (settle_cnt == 2'd0) begin
          state_next = MEASURE;
        end else if (bus.hold) begin
          settle_cnt_next = settle_cnt - 2'd1;
          if (settle_cnt == 2'd1) begin
            state_next = MEASURE;
          end
        end
      end

      MEASURE: begin
        if (bus.hold) begin
          state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        if (better) begin
          best_err_next   = bus.acc_sq_err;
          best_delay_next = sym_delay;
          best_phase_next = sam_phase;
        end
        if (last_cand) begin
          state_next = APPLY;
        end else begin
          if (sam_phase == 2'd3) begin
            sam_phase_next = 2'd0;
            sym_delay_next = sym_delay + 8'd1;
          end else begin
            sam_phase_next = sam_phase + 2'd1;
          end
          settle_cnt_next = SETTLE_PERIODS;
          state_next      = SETTLE;
        end
      end

      APPLY: begin
        sym_delay_next = best_delay;
        sam_phase_next = best_phase;
        locked_next    = (best_err_r < LOCK_THRESH);
        busy_next      = 1'b0;
        done_next      = 1'b1;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, advancing only on symbol-enable cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  // Alignment, best-candidate and status registers, gated by the symbol enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_delay  <= DEFAULT_DELAY;
      sam_phase  <= 2'd0;
      best_delay <= DELAY_MIN;
      best_phase <= 2'd0;
      best_err_r <= ERR_MAX;
      settle_cnt <= 2'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      locked_r   <= 1'b0;
    end else if (clk_en) begin
      sym_delay  <= sym_delay_next;
      sam_phase  <= sam_phase_next;
      best_delay <= best_delay_next;
      best_phase <= best_phase_next;
      best_err_r <= best_err_next;
      settle_cnt <= settle_cnt_next;
      busy_r     <= busy_next;
      done_r     <= done_next;
      locked_r   <= locked_next;
    end
  end

  assign bus.sym_delay_out = sym_delay;
  assign bus.sam_phase_out = sam_phase;
  assign bus.best_err      = best_err_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.locked        = locked_r;

endmodule

// File: tb/tb_sym_delay_search.sv
// Bench for sym_delay_search: directed and randomized error tables, checked
// against a candidate-list / argmin reference model.
module tb_sym_delay_search;

  localparam int          DMIN   = 50;
  localparam int          DMAX   = 54;
  localparam int          NCAND  = 4 * (DMAX - DMIN + 1);
  localparam logic [17:0] THRESH = 18'd4096;
  localparam int          BUDGET = 3000;

  logic clk;
  logic reset;
  logic clk_en;

  sym_delay_search_if bus ();

  sym_delay_search #(
    .DELAY_MIN      (8'd50),
    .DELAY_MAX      (8'd54),
    .DEFAULT_DELAY  (8'd52),
    .SETTLE_PERIODS (2'd1),
    .LOCK_THRESH    (THRESH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  int          checks = 0;
  int          passed = 0;
  int          hold_cnt = 0;
  logic [17:0] err_tab [NCAND];
  logic [9:0]  seq [$];
  logic [9:0]  last_seen;

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for err_sq_gen: registers the error of the alignment in force on each hold edge
  always @(posedge clk) begin
    if (clk_en && bus.hold) begin
      if (bus.sym_delay_out >= 8'(DMIN) && bus.sym_delay_out <= 8'(DMAX))
        bus.acc_sq_err <= err_tab[(int'(bus.sym_delay_out) - DMIN) * 4 + int'(bus.sam_phase_out)];
      else
        bus.acc_sq_err <= 18'h3FFFF;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One enabled cycle: drive inputs on the falling edge, sample 1 ns after the rising edge
  task automatic apply_stimulus(input logic s);
    @(negedge clk);
    clk_en    = 1'b1;
    bus.start = s;
    bus.hold  = (hold_cnt == 15);
    hold_cnt  = (hold_cnt + 1) % 16;
    @(posedge clk);
    #1;
    if (bus.busy && {bus.sym_delay_out, bus.sam_phase_out} !== last_seen) begin
      last_seen = {bus.sym_delay_out, bus.sam_phase_out};
      seq.push_back(last_seen);
    end
  endtask

  // Freeze the enable for 100 cycles while hold/start toggle; outputs must not move
  task automatic freeze_check(input string tag);
    logic [30:0] snap;
    snap = {bus.sym_delay_out, bus.sam_phase_out, bus.best_err, bus.busy, bus.done, bus.locked};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      clk_en    = 1'b0;
      bus.hold  = 1'($urandom);
      bus.start = 1'($urandom);
      @(posedge clk);
      #1;
      check_output({tag, "_frozen"},
                   {1'b0, bus.sym_delay_out, bus.sam_phase_out, bus.best_err, bus.busy, bus.done, bus.locked},
                   {1'b0, snap});
    end
  endtask

  // Reference: candidates in sweep order, first strict minimum wins
  task automatic run_sweep(input string tag, input int restart_at, input int freeze_at);
    int          cyc;
    int          mism;
    logic        fin;
    int          win;
    logic [17:0] best;
    logic [7:0]  exp_d;
    logic [1:0]  exp_p;

    best = 18'h3FFFF;
    win  = 0;
    for (int k = 0; k < NCAND; k++) begin
      if (err_tab[k] < best) begin
        best = err_tab[k];
        win  = k;
      end
    end
    exp_d = 8'(DMIN + win / 4);
    exp_p = 2'(win % 4);

    seq.delete();
    last_seen = '1;
    apply_stimulus(1'b1);
    check_output({tag, "_busy_start"}, 32'(bus.busy), 32'd1);

    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < BUDGET) begin
      apply_stimulus(cyc == restart_at);
      if (cyc == freeze_at) freeze_check(tag);
      if (bus.done) fin = 1'b1;
      cyc++;
    end
    check_output({tag, "_done_seen"}, 32'(fin), 32'd1);
    check_output({tag, "_sym_delay"}, 32'(bus.sym_delay_out), 32'(exp_d));
    check_output({tag, "_sam_phase"}, 32'(bus.sam_phase_out), 32'(exp_p));
    check_output({tag, "_best_err"}, 32'(bus.best_err), 32'(best));
    check_output({tag, "_locked"}, 32'(bus.locked), 32'(best < THRESH));
    check_output({tag, "_busy_end"}, 32'(bus.busy), 32'd0);

    check_output({tag, "_seq_len"}, 32'(seq.size()), 32'(NCAND));
    mism = 0;
    for (int k = 0; k < NCAND; k++) begin
      if (k >= seq.size() || seq[k] !== {8'(DMIN + k / 4), 2'(k % 4)}) mism++;
    end
    check_output({tag, "_seq_order"}, 32'(mism), 32'd0);

    apply_stimulus(1'b0);
    check_output({tag, "_done_width"}, 32'(bus.done), 32'd0);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0);
  endtask

  initial begin
    int cyc;
    reset          = 1'b0;
    clk_en         = 1'b0;
    bus.start      = 1'b0;
    bus.hold       = 1'b0;
    bus.acc_sq_err = 18'h3FFFF;
    for (int k = 0; k < NCAND; k++) err_tab[k] = 18'h3FFFF;

    #23;
    check_output("rst_sym_delay", 32'(bus.sym_delay_out), 32'd52);
    check_output("rst_sam_phase", 32'(bus.sam_phase_out), 32'd0);
    check_output("rst_best_err", 32'(bus.best_err), 32'h3FFFF);
    check_output("rst_status", {29'd0, bus.busy, bus.done, bus.locked}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0);

    $display("[TB] single minimum at 52/0");
    for (int k = 0; k < NCAND; k++) err_tab[k] = 18'd20000;
    err_tab[8] = 18'd1000;
    run_sweep("single_min", -1, -1);

    $display("[TB] tie at 51/2 and 53/1");
    for (int k = 0; k < NCAND; k++) err_tab[k] = 18'd9000;
    err_tab[6]  = 18'd700;
    err_tab[13] = 18'd700;
    run_sweep("tie", -1, -1);

    $display("[TB] minimum above lock threshold");
    for (int k = 0; k < NCAND; k++) err_tab[k] = 18'd30000;
    err_tab[15] = 18'd5000;
    run_sweep("no_lock", -1, -1);

    $display("[TB] all candidates saturated");
    for (int k = 0; k < NCAND; k++) err_tab[k] = 18'h3FFFF;
    run_sweep("saturated", -1, -1);

    $display("[TB] reset mid-sweep at 52/1");
    for (int k = 0; k < NCAND; k++) err_tab[k] = 18'($urandom_range(0, 60000));
    apply_stimulus(1'b1);
    cyc = 0;
    while (!(bus.sym_delay_out == 8'd52 && bus.sam_phase_out == 2'd1) && cyc < BUDGET) begin
      apply_stimulus(1'b0);
      cyc++;
    end
    check_output("midrst_reached", 32'(cyc < BUDGET), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("midrst_sym_delay", 32'(bus.sym_delay_out), 32'd52);
    check_output("midrst_sam_phase", 32'(bus.sam_phase_out), 32'd0);
    check_output("midrst_best_err", 32'(bus.best_err), 32'h3FFFF);
    check_output("midrst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1'b0);
    run_sweep("after_rst", -1, -1);

    $display("[TB] start pulsed while busy");
    for (int k = 0; k < NCAND; k++) err_tab[k] = 18'($urandom_range(0, 60000));
    run_sweep("restart", 150, -1);

    $display("[TB] clock enable frozen mid-sweep");
    for (int k = 0; k < NCAND; k++) err_tab[k] = 18'($urandom_range(0, 60000));
    run_sweep("freeze", -1, 200);

    $display("[TB] random tables with likely ties");
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NCAND; k++) err_tab[k] = 18'($urandom_range(4090, 4100));
      run_sweep($sformatf("random%0d", r), -1, -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
